// File: rtl/edit_mem_buf_release_if.sv
// edit_mem_buf_release_if: init, release and free-pointer bundle; stats signals exist only under EM_BUF_RELEASE_STATS_EN
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 6
`endif
`ifndef READ_COUNT_NBITS
`define READ_COUNT_NBITS 4
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif
interface edit_mem_buf_release_if #(
  parameter int BPTR_NBITS = `EM_BUF_PTR_NBITS,
  parameter int RC_NBITS = `READ_COUNT_NBITS,
  parameter int PID_NBITS = `PORT_ID_NBITS
);
  logic read_count_valid;
  logic [PID_NBITS-1:0] read_count_port_id;
  logic [BPTR_NBITS-1:0] read_count_buf_ptr;
  logic [RC_NBITS-1:0] read_count;
  logic buf_rel_valid;
  logic [BPTR_NBITS-1:0] buf_rel_ptr;
  logic buf_rel_ready;
  logic free_buf_valid;
  logic [BPTR_NBITS-1:0] free_buf_ptr;
  logic free_buf_ready;
  logic rc_underflow;
`ifdef EM_BUF_RELEASE_STATS_EN
  logic stat_clr;
  logic [31:0] stat_freed_cnt;
  logic [31:0] stat_rel_cnt;
  logic [15:0] stat_underflow_cnt;
`endif
  modport slave (
    input read_count_valid, read_count_port_id, read_count_buf_ptr, read_count,
    input buf_rel_valid, buf_rel_ptr, free_buf_ready,
    output buf_rel_ready, free_buf_valid, free_buf_ptr, rc_underflow
`ifdef EM_BUF_RELEASE_STATS_EN
    , input stat_clr, output stat_freed_cnt, stat_rel_cnt, stat_underflow_cnt
`endif
  );
  modport master (
    output read_count_valid, read_count_port_id, read_count_buf_ptr, read_count,
    output buf_rel_valid, buf_rel_ptr, free_buf_ready,
    input buf_rel_ready, free_buf_valid, free_buf_ptr, rc_underflow
`ifdef EM_BUF_RELEASE_STATS_EN
    , output stat_clr, input stat_freed_cnt, stat_rel_cnt, stat_underflow_cnt
`endif
  );
endinterface

// File: rtl/edit_mem_buf_release.sv
// edit_mem_buf_release: per-buffer read-count table, frees a pointer when its count hits zero; optional stats under EM_BUF_RELEASE_STATS_EN
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 6
`endif
`ifndef READ_COUNT_NBITS
`define READ_COUNT_NBITS 4
`endif
module edit_mem_buf_release #(
  parameter int BPTR_NBITS = `EM_BUF_PTR_NBITS,
  parameter int RC_NBITS = `READ_COUNT_NBITS,
  parameter int FIFO_DEPTH_NBITS = 3
) (
  input logic clk,
  input logic rst,
  edit_mem_buf_release_if.slave bus
);
  localparam int FD = 1 << FIFO_DEPTH_NBITS;
  typedef logic [BPTR_NBITS-1:0] ptr_t;
  typedef logic [RC_NBITS-1:0] rc_t;
  rc_t r_mem [1<<BPTR_NBITS];
  ptr_t r_fifo [FD];
  logic r_en, r_init_v, r_s1_v, r_s2_v, r_unf;
  ptr_t r_init_ptr, r_s1_ptr, r_s2_ptr;
  rc_t r_init_cnt, r_s1_data, r_s2_cnt;
  logic [FIFO_DEPTH_NBITS-1:0] r_rp, r_wp;
  logic [FIFO_DEPTH_NBITS:0] r_cnt;
  logic w_acc, w_pop, w_init_wr, w_init_push, w_s2_wr, w_s2_push, w_unf;
  logic [1:0] w_npush;
  rc_t w_s2_new, w_s1_cnt;
  assign w_init_wr = r_init_v & (r_init_cnt != '0);
  assign w_init_push = r_init_v & (r_init_cnt == '0);
  assign w_s2_wr = r_s2_v & (r_s2_cnt != '0);
  assign w_s2_push = r_s2_v & (r_s2_cnt == rc_t'(1));
  assign w_unf = r_s2_v & (r_s2_cnt == '0);
  assign w_s2_new = r_s2_cnt - rc_t'(1);
  assign w_npush = {1'b0, w_s2_push} + {1'b0, w_init_push};
  // Init wins the cycle; the occupancy threshold leaves room for every push already in flight
  assign bus.buf_rel_ready = r_en & ~bus.read_count_valid & (r_cnt <= (FIFO_DEPTH_NBITS+1)'(FD - 4));
  assign w_acc = bus.buf_rel_valid & bus.buf_rel_ready;
  assign bus.free_buf_valid = r_cnt != '0;
  assign bus.free_buf_ptr = r_fifo[r_rp];
  assign w_pop = bus.free_buf_valid & bus.free_buf_ready;
  assign bus.rc_underflow = r_unf;
  // S1 count: the newest write not yet visible in RAM data wins (init is younger than S2)
  assign w_s1_cnt = (w_init_wr && r_init_ptr == r_s1_ptr) ? r_init_cnt : (w_s2_wr && r_s2_ptr == r_s1_ptr) ? w_s2_new : r_s1_data;
  // Table RAM and FIFO storage; the registered read bypasses writes landing on the same edge; S2 push goes first
  always_ff @(posedge clk) begin
    if (w_s2_wr) r_mem[r_s2_ptr] <= w_s2_new;
    if (w_init_wr) r_mem[r_init_ptr] <= r_init_cnt;
    r_s1_data <= (w_init_wr && r_init_ptr == bus.buf_rel_ptr) ? r_init_cnt : (w_s2_wr && r_s2_ptr == bus.buf_rel_ptr) ? w_s2_new : r_mem[bus.buf_rel_ptr];
    if (w_s2_push) r_fifo[r_wp] <= r_s2_ptr;
    if (w_init_push) r_fifo[w_s2_push ? r_wp + 1'b1 : r_wp] <= r_init_ptr;
    r_init_ptr <= bus.read_count_buf_ptr;
    r_init_cnt <= bus.read_count;
    r_s1_ptr <= bus.buf_rel_ptr;
    r_s2_ptr <= r_s1_ptr;
    r_s2_cnt <= w_s1_cnt;
  end
  // Pipeline valids, FIFO pointers and the sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= 1'b0;
      r_init_v <= 1'b0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_unf <= 1'b0;
      r_rp <= '0;
      r_wp <= '0;
      r_cnt <= '0;
    end else begin
      r_en <= 1'b1;
      r_init_v <= bus.read_count_valid;
      r_s1_v <= w_acc;
      r_s2_v <= r_s1_v;
      r_unf <= r_unf | w_unf;
      r_wp <= r_wp + FIFO_DEPTH_NBITS'(w_npush);
      r_rp <= r_rp + FIFO_DEPTH_NBITS'(w_pop);
      r_cnt <= r_cnt + (FIFO_DEPTH_NBITS+1)'(w_npush) - (FIFO_DEPTH_NBITS+1)'(w_pop);
    end
  end
  assert property (@(posedge clk) disable iff (rst) (32'(r_cnt) + 32'(w_npush)) <= (32'(FD) + 32'(w_pop)));
`ifdef EM_BUF_RELEASE_STATS_EN
  logic [31:0] r_freed, r_rel;
  logic [15:0] r_uc;
  assign bus.stat_freed_cnt = r_freed;
  assign bus.stat_rel_cnt = r_rel;
  assign bus.stat_underflow_cnt = r_uc;
  // Statistics: a clear pulse drops that cycle's events and restarts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freed <= '0;
      r_rel <= '0;
      r_uc <= '0;
    end else begin
      r_freed <= bus.stat_clr ? '0 : r_freed + 32'(w_pop);
      r_rel <= bus.stat_clr ? '0 : r_rel + 32'(w_acc);
      r_uc <= bus.stat_clr ? '0 : r_uc + 16'(w_unf & ~&r_uc);
    end
  end
`endif
endmodule
